// File: rtl/uart_rx_controller_pkg.sv
// Shared types for the UART receive-path controller: FSM state codes,
// error-flag bit positions and the frame entry stored in the FIFO.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED   = 2'd0,
      ST_RESET_HOLD = 2'd1,
      ST_IDLE       = 2'd2,
      ST_RECEIVING  = 2'd3
   } rx_ctrl_state_e;

   localparam int unsigned ERR_STOP   = 2;
   localparam int unsigned ERR_START  = 1;
   localparam int unsigned ERR_PARITY = 0;

   localparam int unsigned ERR_W   = 3;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned ENTRY_W = ERR_W + DATA_W;

   typedef struct packed {
      logic [ERR_W-1:0]  err;
      logic [DATA_W-1:0] data;
   } frame_entry_t;

   // True when any receiver error flag is set for the frame.
   function automatic logic has_error(input logic [ERR_W-1:0] e);
      return e[ERR_STOP] | e[ERR_START] | e[ERR_PARITY];
   endfunction

endpackage

// File: rtl/uart_rx_controller_if.sv
// Host-side frame stream: head of the frame FIFO offered with valid/ready.
interface uart_rx_controller_if;
   import uart_rx_ctrl_pkg::*;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ERR_W-1:0]  out_error;

   modport master (output out_valid, output out_data, output out_error, input out_ready);
   modport slave  (input out_valid, input out_data, input out_error, output out_ready);

endinterface

// File: rtl/uart_rx_controller_rx_frame_fifo.sv
// Small synchronous FIFO of received frames. A push while full is ignored
// unless a pop happens in the same cycle; the head reads as zero when empty.
module rx_frame_fifo
   import uart_rx_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  frame_entry_t wr_entry,
   input  logic         pop,
   output frame_entry_t rd_entry,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   frame_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign rd_entry = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap on the power-of-two depth.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive-path controller: sequences the receiver's reset and
// configuration, turns frame completions into FIFO entries and keeps
// overrun / error-count status.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// DISABLED    | receiver held in reset, waiting for an enabling cfg_write
// RESET_HOLD  | receiver held in reset for RESET_HOLD_CYCLES after new config
// IDLE        | receiver running, between frames; config may be applied
// RECEIVING   | frame in progress; config writes parked as pending
module uart_rx_controller
   import uart_rx_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH        = 4,
   parameter int unsigned RESET_HOLD_CYCLES = 2,
   parameter logic [1:0]  DEFAULT_BAUD      = 2'b10,
   parameter logic [1:0]  DEFAULT_PARITY    = 2'b01
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        cfg_write,
   input  logic                        cfg_enable,
   input  logic [1:0]                  cfg_baud,
   input  logic [1:0]                  cfg_parity,
   input  logic                        cfg_drop_errors,
   input  logic                        clear_status,
   input  logic                        rx_active,
   input  logic                        rx_done,
   input  logic [ERR_W-1:0]            rx_error,
   input  logic [DATA_W-1:0]           rx_data,
   output logic                        rx_reset_n,
   output logic [1:0]                  baud_rate,
   output logic [1:0]                  parity_type,
   uart_rx_controller_if.master        out_if,
   output logic                        overrun,
   output logic [7:0]                  err_count,
   output logic                        cfg_busy
);

   localparam logic [1:0] S_DISABLED   = ST_DISABLED;
   localparam logic [1:0] S_RESET_HOLD = ST_RESET_HOLD;
   localparam logic [1:0] S_IDLE       = ST_IDLE;
   localparam logic [1:0] S_RECEIVING  = ST_RECEIVING;

   localparam int unsigned  HOLD_W    = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_HOLD_CYCLES - 1);

   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [HOLD_W-1:0] hold_q;
   logic              rx_done_q;
   logic              rx_active_q;
   logic              pend_q;
   logic [1:0]        pend_baud_q;
   logic [1:0]        pend_parity_q;
   logic              drop_q;

   logic              apply_cfg;
   logic              apply_pend;
   logic              pend_set;
   logic              pend_clr;

   logic              live;
   logic              done_rise;
   logic              active_fall;
   logic              frame_end;
   logic              err_evt;
   logic              push_req;
   logic              pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic              lost;
   frame_entry_t      wr_entry;
   frame_entry_t      rd_entry;

   // A done level that was already high while disabled or in reset hold is
   // tracked by rx_done_q, so it cannot show up as an edge after re-enable.
   assign live        = (state_q == S_IDLE) || (state_q == S_RECEIVING);
   assign done_rise   = live && rx_done && !rx_done_q;
   assign active_fall = rx_active_q && !rx_active;
   assign frame_end   = done_rise || active_fall;
   assign err_evt     = done_rise && has_error(rx_error);
   assign push_req    = done_rise && !(drop_q && has_error(rx_error));
   assign pop         = out_if.out_valid && out_if.out_ready;
   assign lost        = push_req && fifo_full && !pop;
   assign wr_entry    = '{err: rx_error, data: rx_data};
   assign cfg_busy    = pend_q || (state_q == S_RESET_HOLD);

   assign out_if.out_valid = !fifo_empty;
   assign out_if.out_data  = rd_entry.data;
   assign out_if.out_error = rd_entry.err;

   // Next-state and config-apply decisions.
   always_comb begin
      state_d    = state_q;
      apply_cfg  = 1'b0;
      apply_pend = 1'b0;
      pend_set   = 1'b0;
      pend_clr   = 1'b0;
      case (state_q)
         S_DISABLED: begin
            if (cfg_write && cfg_enable) begin
               state_d   = S_RESET_HOLD;
               apply_cfg = 1'b1;
            end
         end
         S_RESET_HOLD: begin
            if (cfg_write) begin
               if (cfg_enable) begin
                  state_d   = S_RESET_HOLD;
                  apply_cfg = 1'b1;
               end else begin
                  state_d = S_DISABLED;
               end
            end else if (hold_q == '0) begin
               state_d = S_IDLE;
            end
         end
         S_IDLE: begin
            if (cfg_write) begin
               if (cfg_enable) begin
                  state_d   = S_RESET_HOLD;
                  apply_cfg = 1'b1;
               end else begin
                  state_d = S_DISABLED;
               end
            end else if (rx_active) begin
               state_d = S_RECEIVING;
            end
         end
         S_RECEIVING: begin
            if (cfg_write && !cfg_enable) begin
               state_d  = S_DISABLED;
               pend_clr = 1'b1;
            end else if (frame_end) begin
               pend_clr = 1'b1;
               if (cfg_write) begin
                  state_d   = S_RESET_HOLD;
                  apply_cfg = 1'b1;
               end else if (pend_q) begin
                  state_d    = S_RESET_HOLD;
                  apply_pend = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (cfg_write) begin
               pend_set = 1'b1;
            end
         end
         default: state_d = S_DISABLED;
      endcase
   end

   // State, reset-hold down-counter, receiver reset and applied config.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_DISABLED;
         hold_q      <= '0;
         rx_reset_n  <= 1'b0;
         baud_rate   <= DEFAULT_BAUD;
         parity_type <= DEFAULT_PARITY;
      end else begin
         state_q    <= state_d;
         rx_reset_n <= (state_d == S_IDLE) || (state_d == S_RECEIVING);
         if (apply_cfg || apply_pend) begin
            hold_q <= HOLD_LOAD;
         end else if ((state_q == S_RESET_HOLD) && (hold_q != '0)) begin
            hold_q <= hold_q - HOLD_W'(1);
         end
         if (apply_cfg) begin
            baud_rate   <= cfg_baud;
            parity_type <= cfg_parity;
         end else if (apply_pend) begin
            baud_rate   <= pend_baud_q;
            parity_type <= pend_parity_q;
         end
      end
   end

   // Pending config parked during a frame; the latest write wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q        <= 1'b0;
         pend_baud_q   <= '0;
         pend_parity_q <= '0;
      end else if (pend_clr) begin
         pend_q <= 1'b0;
      end else if (pend_set) begin
         pend_q        <= 1'b1;
         pend_baud_q   <= cfg_baud;
         pend_parity_q <= cfg_parity;
      end
   end

   // Edge-detect history and the drop-on-error filter setting.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_done_q   <= 1'b0;
         rx_active_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         rx_done_q   <= rx_done;
         rx_active_q <= rx_active;
         if (cfg_write) drop_q <= cfg_drop_errors;
      end
   end

   // Sticky overrun and saturating error count; a same-cycle event beats clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         overrun   <= 1'b0;
         err_count <= '0;
      end else begin
         if (lost)              overrun <= 1'b1;
         else if (clear_status) overrun <= 1'b0;
         if (clear_status)                      err_count <= {7'd0, err_evt};
         else if (err_evt && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

   rx_frame_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push_req),
      .wr_entry (wr_entry),
      .pop      (pop),
      .rd_entry (rd_entry),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: a directed vector table, hand-written
// sequences for the multi-cycle cases, then random traffic, all compared
// each cycle against a behavioural model of the controller.
module tb_uart_rx_controller;
   import uart_rx_ctrl_pkg::*;

   localparam int DEPTH = 4;
   localparam int HOLD  = 2;

   logic       clock = 1'b0;
   logic       reset;
   logic       cfg_write, cfg_enable, cfg_drop_errors, clear_status;
   logic [1:0] cfg_baud, cfg_parity;
   logic       rx_active, rx_done, out_ready;
   logic [2:0] rx_error;
   logic [7:0] rx_data;
   logic       rx_reset_n, overrun, cfg_busy;
   logic [1:0] baud_rate, parity_type;
   logic [7:0] err_count;

   uart_rx_controller_if out_if();
   assign out_if.out_ready = out_ready;

   always #5 clock = ~clock;

   uart_rx_controller #(
      .FIFO_DEPTH        (DEPTH),
      .RESET_HOLD_CYCLES (HOLD),
      .DEFAULT_BAUD      (2'b10),
      .DEFAULT_PARITY    (2'b01)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cfg_write       (cfg_write),
      .cfg_enable      (cfg_enable),
      .cfg_baud        (cfg_baud),
      .cfg_parity      (cfg_parity),
      .cfg_drop_errors (cfg_drop_errors),
      .clear_status    (clear_status),
      .rx_active       (rx_active),
      .rx_done         (rx_done),
      .rx_error        (rx_error),
      .rx_data         (rx_data),
      .rx_reset_n      (rx_reset_n),
      .baud_rate       (baud_rate),
      .parity_type     (parity_type),
      .out_if          (out_if),
      .overrun         (overrun),
      .err_count       (err_count),
      .cfg_busy        (cfg_busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_en, m_frame, m_pend, m_drop, m_ovr, m_done_prev, m_act_prev;
   int         m_hold;      // remaining reset-hold cycles, 0 = receiver running
   int         m_cnt;
   bit [1:0]   m_baud, m_par, p_baud, p_par;
   bit [10:0]  mq[$];

   function automatic void model_reset();
      m_en = 0; m_frame = 0; m_pend = 0; m_drop = 0; m_ovr = 0;
      m_done_prev = 0; m_act_prev = 0; m_hold = 0; m_cnt = 0;
      m_baud = 2'b10; m_par = 2'b01; p_baud = 0; p_par = 0;
      mq.delete();
   endfunction

   function automatic void start_hold(input bit [1:0] b, input bit [1:0] p);
      m_en = 1; m_hold = HOLD; m_frame = 0; m_baud = b; m_par = p;
   endfunction

   function automatic void model_step();
      bit live, rise, fall, anyerr, pop, push, ovf, evt;
      bit [10:0] dummy;
      live   = m_en && (m_hold == 0);
      rise   = live && rx_done && !m_done_prev;
      fall   = m_act_prev && !rx_active;
      anyerr = |rx_error;
      evt    = rise && anyerr;
      pop    = (mq.size() != 0) && out_ready;
      push   = rise && !(m_drop && anyerr);
      ovf    = 0;
      if (pop) dummy = mq.pop_front();
      if (push) begin
         if (mq.size() < DEPTH) mq.push_back({rx_error, rx_data});
         else ovf = 1;
      end
      if (ovf) m_ovr = 1;
      else if (clear_status) m_ovr = 0;
      if (clear_status) m_cnt = evt ? 1 : 0;
      else if (evt && m_cnt < 255) m_cnt++;

      if (!m_en) begin
         if (cfg_write && cfg_enable) start_hold(cfg_baud, cfg_parity);
      end else if (m_hold > 0) begin
         if (cfg_write) begin
            if (cfg_enable) start_hold(cfg_baud, cfg_parity);
            else m_en = 0;
         end else m_hold--;
      end else if (!m_frame) begin
         if (cfg_write) begin
            if (cfg_enable) start_hold(cfg_baud, cfg_parity);
            else m_en = 0;
         end else if (rx_active) m_frame = 1;
      end else begin
         if (cfg_write && !cfg_enable) begin
            m_en = 0; m_frame = 0; m_pend = 0;
         end else if (rise || fall) begin
            m_frame = 0;
            if (cfg_write) start_hold(cfg_baud, cfg_parity);
            else if (m_pend) start_hold(p_baud, p_par);
            m_pend = 0;
         end else if (cfg_write) begin
            m_pend = 1; p_baud = cfg_baud; p_par = cfg_parity;
         end
      end
      if (cfg_write) m_drop = cfg_drop_errors;
      m_done_prev = rx_done;
      m_act_prev  = rx_active;
   endfunction

   task automatic check_model(input string tag);
      bit v;
      v = (mq.size() != 0);
      chk({tag, " rx_reset_n"}, rx_reset_n, (m_en && m_hold == 0));
      chk({tag, " baud_rate"}, baud_rate, m_baud);
      chk({tag, " parity_type"}, parity_type, m_par);
      chk({tag, " out_valid"}, out_if.out_valid, v);
      chk({tag, " out_data"}, out_if.out_data, v ? mq[0][7:0] : 8'h00);
      chk({tag, " out_error"}, out_if.out_error, v ? mq[0][10:8] : 3'b000);
      chk({tag, " overrun"}, overrun, m_ovr);
      chk({tag, " err_count"}, err_count, m_cnt);
      chk({tag, " cfg_busy"}, cfg_busy, (m_pend || (m_en && m_hold > 0)));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clock);
      #1;
      check_model(tag);
   endtask

   task automatic frame(input logic [7:0] d, input logic [2:0] e, input string tag);
      rx_done = 1; rx_data = d; rx_error = e;
      tick(tag);
      rx_done = 0;
      tick(tag);
   endtask

   task automatic write_cfg(input bit en, input bit [1:0] b, input bit [1:0] p, input bit drop, input string tag);
      cfg_write = 1; cfg_enable = en; cfg_baud = b; cfg_parity = p; cfg_drop_errors = drop;
      tick(tag);
      cfg_write = 0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit cw, en; bit [1:0] baud, par; bit act, done; bit [7:0] data; bit [2:0] err; bit rdy;
      bit x_rstn; bit [1:0] x_baud, x_par; bit x_valid; bit [7:0] x_data; bit [2:0] x_err;
      bit x_busy; bit [7:0] x_cnt;
   } vec_t;

   function automatic vec_t mk(bit cw, bit en, bit [1:0] baud, bit [1:0] par, bit act, bit done,
                               bit [7:0] data, bit [2:0] err, bit rdy, bit x_rstn, bit [1:0] x_baud,
                               bit [1:0] x_par, bit x_valid, bit [7:0] x_data, bit [2:0] x_err,
                               bit x_busy, bit [7:0] x_cnt);
      vec_t v;
      v = '{cw, en, baud, par, act, done, data, err, rdy,
            x_rstn, x_baud, x_par, x_valid, x_data, x_err, x_busy, x_cnt};
      return v;
   endfunction

   vec_t vec[13];

   initial begin
      //           cw en bd pr ac dn data   er rdy | rstn bd pr v  data   er bsy cnt
      vec[0]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,    0,   2, 1, 0, 8'h00, 0, 0,  0);
      vec[1]  = mk(1, 1, 3, 2, 0, 0, 8'h00, 0, 0,    0,   3, 2, 0, 8'h00, 0, 1,  0);
      vec[2]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,    0,   3, 2, 0, 8'h00, 0, 1,  0);
      vec[3]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,    1,   3, 2, 0, 8'h00, 0, 0,  0);
      vec[4]  = mk(0, 0, 0, 0, 0, 1, 8'hA5, 0, 1,    1,   3, 2, 1, 8'hA5, 0, 0,  0);
      vec[5]  = mk(0, 0, 0, 0, 0, 1, 8'hA5, 0, 1,    1,   3, 2, 0, 8'h00, 0, 0,  0);
      vec[6]  = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,    1,   3, 2, 0, 8'h00, 0, 0,  0);
      vec[7]  = mk(0, 0, 0, 0, 1, 0, 8'h00, 0, 0,    1,   3, 2, 0, 8'h00, 0, 0,  0);
      vec[8]  = mk(1, 1, 0, 0, 1, 0, 8'h00, 0, 0,    1,   3, 2, 0, 8'h00, 0, 1,  0);
      vec[9]  = mk(0, 0, 0, 0, 0, 1, 8'h5A, 4, 0,    0,   0, 0, 1, 8'h5A, 4, 1,  1);
      vec[10] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,    0,   0, 0, 1, 8'h5A, 4, 1,  1);
      vec[11] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 0,    1,   0, 0, 1, 8'h5A, 4, 0,  1);
      vec[12] = mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 1,    1,   0, 0, 0, 8'h00, 0, 0,  1);

      reset = 1; cfg_write = 0; cfg_enable = 0; cfg_baud = 0; cfg_parity = 0;
      cfg_drop_errors = 0; clear_status = 0; rx_active = 0; rx_done = 0;
      rx_error = 0; rx_data = 0; out_ready = 0;
      repeat (3) @(posedge clock);
      #1;
      reset = 0;
      model_reset();
      check_model("reset");
      chk("reset rx_reset_n", rx_reset_n, 1'b0);
      chk("reset baud_rate", baud_rate, 2'b10);
      chk("reset parity_type", parity_type, 2'b01);

      for (int i = 0; i < 13; i++) begin
         cfg_write = vec[i].cw; cfg_enable = vec[i].en; cfg_baud = vec[i].baud;
         cfg_parity = vec[i].par; cfg_drop_errors = 0; clear_status = 0;
         rx_active = vec[i].act; rx_done = vec[i].done; rx_data = vec[i].data;
         rx_error = vec[i].err; out_ready = vec[i].rdy;
         tick($sformatf("vec%0d model", i));
         chk($sformatf("vec%0d rx_reset_n", i), rx_reset_n, vec[i].x_rstn);
         chk($sformatf("vec%0d baud_rate", i), baud_rate, vec[i].x_baud);
         chk($sformatf("vec%0d parity_type", i), parity_type, vec[i].x_par);
         chk($sformatf("vec%0d out_valid", i), out_if.out_valid, vec[i].x_valid);
         chk($sformatf("vec%0d out_data", i), out_if.out_data, vec[i].x_data);
         chk($sformatf("vec%0d out_error", i), out_if.out_error, vec[i].x_err);
         chk($sformatf("vec%0d cfg_busy", i), cfg_busy, vec[i].x_busy);
         chk($sformatf("vec%0d err_count", i), err_count, vec[i].x_cnt);
      end
      cfg_write = 0; rx_active = 0; rx_done = 0; rx_error = 0; out_ready = 0;

      // Overrun: five frames into a four-deep FIFO, then drain in order.
      for (int d = 1; d <= 5; d++) frame(8'(d), 3'b000, "ovr fill");
      chk("ovr overrun set", overrun, 1'b1);
      chk("ovr head", out_if.out_data, 8'h01);
      out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovr drain%0d", k), out_if.out_data, 8'(k + 1));
         tick("ovr drain");
      end
      out_ready = 0;
      chk("ovr drained", out_if.out_valid, 1'b0);
      clear_status = 1;
      tick("ovr clear");
      clear_status = 0;
      chk("ovr cleared", overrun, 1'b0);

      // Full FIFO with push and pop in the same cycle: no overrun.
      for (int d = 1; d <= 4; d++) frame(8'(d), 3'b000, "pp fill");
      rx_done = 1; rx_data = 8'h66; out_ready = 1;
      tick("pp same");
      chk("pp no overrun", overrun, 1'b0);
      chk("pp head advanced", out_if.out_data, 8'h02);
      rx_done = 0;
      repeat (5) tick("pp drain");
      out_ready = 0;

      // Drop-on-error and err_count saturation.
      write_cfg(1, 0, 0, 1, "drop cfg");
      repeat (2) tick("drop hold");
      chk("drop running", rx_reset_n, 1'b1);
      clear_status = 1;
      tick("drop clr");
      clear_status = 0;
      frame(8'h3C, 3'b001, "drop frame");
      chk("drop not pushed", out_if.out_valid, 1'b0);
      chk("drop err_count", err_count, 8'd1);
      for (int i = 0; i < 300; i++) frame(8'(i), 3'($urandom_range(1, 7)), "sat");
      chk("sat err_count", err_count, 8'd255);

      // Config written during a frame is deferred until the frame ends.
      write_cfg(1, 3, 1, 0, "pend cfg");
      repeat (2) tick("pend hold");
      rx_active = 1;
      tick("pend start");
      write_cfg(1, 0, 2, 0, "pend write");
      chk("pend baud kept", baud_rate, 2'd3);
      chk("pend busy", cfg_busy, 1'b1);
      repeat (3) tick("pend wait");
      chk("pend still busy", cfg_busy, 1'b1);
      chk("pend rstn high", rx_reset_n, 1'b1);
      rx_done = 1; rx_data = 8'h77; rx_error = 0;
      tick("pend end");
      chk("pend baud applied", baud_rate, 2'd0);
      chk("pend parity applied", parity_type, 2'd2);
      chk("pend hold", rx_reset_n, 1'b0);
      rx_done = 0; rx_active = 0; out_ready = 1;
      repeat (3) tick("pend settle");
      out_ready = 0;

      // Disable mid-frame; done level held across re-enable is not a frame.
      rx_active = 1;
      tick("dis start");
      cfg_write = 1; cfg_enable = 0;
      rx_done = 0;
      tick("dis write");
      cfg_write = 0;
      chk("dis rstn low", rx_reset_n, 1'b0);
      rx_done = 1; rx_data = 8'hEE; rx_active = 0;
      repeat (2) tick("dis held");
      write_cfg(1, 1, 1, 0, "dis reen");
      repeat (4) tick("dis run");
      chk("dis no frame", out_if.out_valid, 1'b0);
      chk("dis running", rx_reset_n, 1'b1);
      rx_done = 0;
      tick("dis done low");

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         cfg_write       = ($urandom_range(0, 99) < 4);
         cfg_enable      = ($urandom_range(0, 9) != 0);
         cfg_baud        = 2'($urandom);
         cfg_parity      = 2'($urandom);
         cfg_drop_errors = ($urandom_range(0, 3) == 0);
         clear_status    = ($urandom_range(0, 99) < 3);
         if ($urandom_range(0, 9) == 0) rx_active = ~rx_active;
         if ($urandom_range(0, 4) == 0) rx_done = ~rx_done;
         rx_error  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
         rx_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
